// File: rtl/alu_control_seq.sv
// alu_control_seq: registered, handshaked ALU control unit.
// Decodes ALUOp/funct into an ALU operation code, and holds MUL/DIV codes
// for a fixed latency while asserting busy so the datapath can stall.
module alu_control_seq #(
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              illegal,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    // The counter is loaded with LAT-1 so busy stays high for exactly LAT cycles.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_illegal;

    logic [3:0]        w_code;
    logic              w_illegal;
    logic              w_multi;
    logic [CNT_W-1:0]  w_lat_m1;
    logic              w_accept;

    // Decode the incoming request; unknown R-type functs fall back to ADD and flag illegal.
    always_comb begin
        w_code    = 4'b0010;
        w_illegal = 1'b0;
        w_multi   = 1'b0;
        w_lat_m1  = '0;
        case (alu_op)
            2'b00: w_code = 4'b0010;
            2'b01: w_code = 4'b0110;
            2'b11: w_code = 4'b0001;
            default: begin
                case (funct)
                    6'b100000: w_code = 4'b0010;
                    6'b100010: w_code = 4'b0110;
                    6'b100100: w_code = 4'b0000;
                    6'b100101: w_code = 4'b0001;
                    6'b100111: w_code = 4'b1100;
                    6'b101010: w_code = 4'b0111;
                    6'b000000: w_code = 4'b1000;
                    6'b000010: w_code = 4'b1001;
                    6'b011000: begin
                        w_code   = 4'b1010;
                        w_multi  = 1'b1;
                        w_lat_m1 = MUL_LOAD;
                    end
                    6'b011010: begin
                        w_code   = 4'b1011;
                        w_multi  = 1'b1;
                        w_lat_m1 = DIV_LOAD;
                    end
                    default: begin
                        w_code    = 4'b0010;
                        w_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Ready when idle, or when the held result is being consumed this cycle (back-to-back).
    assign in_ready  = rst_n & ((r_state == S_IDLE) | ((r_state == S_OUT) & out_ready));
    assign w_accept  = in_valid & in_ready;
    assign out_valid = (r_state == S_OUT);
    assign busy      = (r_state == S_BUSY);
    assign alu_ctrl  = r_ctrl;
    assign illegal   = r_illegal;

    // Handshake state machine: capture on accept, count down multi-cycle ops, hold output until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ctrl    <= '0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_ctrl    <= CTRL_W'(w_code);
            r_illegal <= w_illegal;
            if (w_multi) begin
                r_state <= S_BUSY;
                r_cnt   <= w_lat_m1;
            end else begin
                r_state <= S_OUT;
            end
        end else begin
            case (r_state)
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= S_OUT;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// tb_alu_control_seq: directed and randomized transactions against a
// transaction-level reference of the ALU control decode and latency rules.
module tb_alu_control_seq;

    localparam int CTRL_W  = 4;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 16;
    localparam int CNT_W   = 5;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              illegal;
    logic              busy;

    int nChecks = 0;
    int nFail   = 0;

    alu_control_seq #(
        .CTRL_W (CTRL_W),
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_op   (alu_op),
        .funct    (funct),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .alu_ctrl (alu_ctrl),
        .illegal  (illegal),
        .busy     (busy)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: operation code, illegal flag and busy cycles for one request.
    task automatic refDecode(input logic [1:0] op, input logic [5:0] fn,
                             output logic [3:0] code, output logic ill, output int lat);
        ill = 1'b0;
        lat = 0;
        if (op == 2'b00)      code = 4'b0010;
        else if (op == 2'b01) code = 4'b0110;
        else if (op == 2'b11) code = 4'b0001;
        else begin
            case (fn)
                6'h20: code = 4'b0010;
                6'h22: code = 4'b0110;
                6'h24: code = 4'b0000;
                6'h25: code = 4'b0001;
                6'h27: code = 4'b1100;
                6'h2A: code = 4'b0111;
                6'h00: code = 4'b1000;
                6'h02: code = 4'b1001;
                6'h18: begin code = 4'b1010; lat = MUL_LAT; end
                6'h1A: begin code = 4'b1011; lat = DIV_LAT; end
                default: begin code = 4'b0010; ill = 1'b1; end
            endcase
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] fn);
        in_valid = 1'b1;
        alu_op   = op;
        funct    = fn;
        #1;
    endtask

    // One full transaction from IDLE: request, optional busy phase, stall, drain.
    task automatic runTransaction(input logic [1:0] op, input logic [5:0] fn, input int stall);
        logic [3:0] code;
        logic       ill;
        int         lat;
        refDecode(op, fn, code, ill, lat);
        applyStimulus(op, fn);
        checkOutput("in_ready_at_request", 32'(in_ready), 32'd1);
        tick();
        in_valid  = 1'b0;
        alu_op    = 2'($urandom);
        funct     = 6'($urandom);
        out_ready = 1'($urandom);
        for (int i = 0; i < lat; i++) begin
            checkOutput("busy_high", 32'(busy), 32'd1);
            checkOutput("busy_no_valid", 32'(out_valid), 32'd0);
            checkOutput("busy_not_ready", 32'(in_ready), 32'd0);
            checkOutput("busy_ctrl", 32'(alu_ctrl), 32'(code));
            tick();
        end
        checkOutput("out_valid", 32'(out_valid), 32'd1);
        checkOutput("out_not_busy", 32'(busy), 32'd0);
        checkOutput("out_ctrl", 32'(alu_ctrl), 32'(code));
        checkOutput("out_illegal", 32'(illegal), 32'(ill));
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            #1;
            checkOutput("stall_not_ready", 32'(in_ready), 32'd0);
            tick();
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_ctrl", 32'(alu_ctrl), 32'(code));
            checkOutput("stall_illegal", 32'(illegal), 32'(ill));
        end
        out_ready = 1'b1;
        #1;
        checkOutput("drain_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("idle_valid", 32'(out_valid), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_ready", 32'(in_ready), 32'd1);
    endtask

    logic [5:0] legalFn [10];
    logic [1:0] rOp;
    logic [5:0] rFn;

    // Directed steps followed by randomized transactions.
    initial begin
        legalFn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h18, 6'h1A};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        alu_op    = 2'b00;
        funct     = 6'h00;
        out_ready = 1'b1;
        #1;
        checkOutput("rst_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_ctrl", 32'(alu_ctrl), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_ready", 32'(in_ready), 32'd1);
        checkOutput("post_rst_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 10; i++) runTransaction(2'b10, legalFn[i], 0);
        runTransaction(2'b00, 6'h3F, 0);
        runTransaction(2'b01, 6'h3F, 0);
        runTransaction(2'b11, 6'h3F, 0);
        runTransaction(2'b00, 6'h20, 3);
        runTransaction(2'b10, 6'h3F, 1);

        // Back-to-back SUB, AND, NOR, then MUL straight out of OUT.
        out_ready = 1'b1;
        applyStimulus(2'b01, 6'h3F);
        tick();
        checkOutput("b2b_sub_ctrl", 32'(alu_ctrl), 32'h6);
        checkOutput("b2b_sub_valid", 32'(out_valid), 32'd1);
        checkOutput("b2b_sub_ready", 32'(in_ready), 32'd1);
        applyStimulus(2'b10, 6'h24);
        tick();
        checkOutput("b2b_and_ctrl", 32'(alu_ctrl), 32'h0);
        checkOutput("b2b_and_valid", 32'(out_valid), 32'd1);
        checkOutput("b2b_and_ready", 32'(in_ready), 32'd1);
        applyStimulus(2'b10, 6'h27);
        tick();
        checkOutput("b2b_nor_ctrl", 32'(alu_ctrl), 32'hC);
        checkOutput("b2b_nor_valid", 32'(out_valid), 32'd1);
        applyStimulus(2'b10, 6'h18);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < MUL_LAT; i++) begin
            checkOutput("b2b_mul_busy", 32'(busy), 32'd1);
            checkOutput("b2b_mul_ctrl", 32'(alu_ctrl), 32'hA);
            tick();
        end
        checkOutput("b2b_mul_valid", 32'(out_valid), 32'd1);
        tick();
        checkOutput("b2b_drained", 32'(out_valid), 32'd0);

        // Reset during DIV once the counter has reached 7.
        applyStimulus(2'b10, 6'h1A);
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        checkOutput("div_busy_before_rst", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_ready", 32'(in_ready), 32'd0);
        checkOutput("midrst_ctrl", 32'(alu_ctrl), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < DIV_LAT + 4; i++) begin
            tick();
            checkOutput("abort_no_valid", 32'(out_valid), 32'd0);
            checkOutput("abort_no_busy", 32'(busy), 32'd0);
        end
        runTransaction(2'b10, 6'h2A, 0);

        // Reset while an illegal result is held under backpressure.
        applyStimulus(2'b10, 6'h3F);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        checkOutput("held_illegal", 32'(illegal), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("outrst_illegal", 32'(illegal), 32'd0);
        checkOutput("outrst_valid", 32'(out_valid), 32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        checkOutput("outrst_idle_valid", 32'(out_valid), 32'd0);

        for (int n = 0; n < 30; n++) begin
            rOp = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) rFn = 6'($urandom);
            else rFn = legalFn[$urandom_range(0, 9)];
            runTransaction(rOp, rFn, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    // Safety net in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Registered, handshaked ALU control unit for the next processor revision.
- Decodes the 2-bit ALUOp from main control plus the 6-bit R-type funct into a CTRL_W-bit ALU operation code.
- Extends the operation set with shifts, NOR, SLT and multi-cycle MULT/DIV. For MULT/DIV it holds the code for a parametrised number of cycles and signals busy, so the datapath can stall.
- Sits between main control/decode and the ALU/multiplier-divider.

Parameters:
- CTRL_W, 4: width of alu_ctrl. Must be >= 4. Codes are zero-extended into upper bits.
- MUL_LAT, 4: cycles busy is held for MULT. Must be >= 1.
- DIV_LAT, 16: cycles busy is held for DIV. Must be >= 1.
- CNT_W, 5: latency counter width. Must hold max(MUL_LAT, DIV_LAT)-1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  alu_op/funct valid
- in_ready  output  1  block accepts a new request
- alu_op  input  2  00 add, 01 sub, 10 R-type (use funct), 11 or
- funct  input  6  R-type function field
- out_valid  output  1  alu_ctrl/illegal valid for consumer
- out_ready  input  1  consumer takes output
- alu_ctrl  output  CTRL_W  ALU operation code
- illegal  output  1  unsupported funct with alu_op=10
- busy  output  1  multi-cycle op in progress; datapath must stall

Behaviour:
- Decode (combinational, registered on accept):
  - alu_op 00 -> ADD 0010
  - alu_op 01 -> SUB 0110
  - alu_op 11 -> OR 0001
  - alu_op 10 with funct:
    - 100000 -> ADD 0010
    - 100010 -> SUB 0110
    - 100100 -> AND 0000
    - 100101 -> OR 0001
    - 100111 -> NOR 1100
    - 101010 -> SLT 0111
    - 000000 -> SLL 1000
    - 000010 -> SRL 1001
    - 011000 -> MUL 1010 (multi-cycle, MUL_LAT)
    - 011010 -> DIV 1011 (multi-cycle, DIV_LAT)
    - any other funct -> ADD 0010 with illegal=1, single-cycle
  - funct is ignored unless alu_op=10.
- Accept: in_valid && in_ready at a rising edge. Inputs are sampled only then; changes at other times are ignored.
- States:
  - IDLE: in_ready=1, out_valid=0, busy=0.
  - BUSY: busy=1, out_valid=0, alu_ctrl holds the MUL/DIV code, in_ready=0.
  - OUT: out_valid=1, alu_ctrl/illegal held stable until out_ready. in_ready=out_ready.
- Transitions:
  - IDLE, accept of a single-cycle op -> OUT. Latency 1: out_valid is high the cycle after accept.
  - IDLE or OUT, accept of MUL/DIV -> BUSY, cnt loaded with LAT-1.
  - BUSY: cnt decrements each cycle. At cnt==0 -> OUT. busy is high exactly LAT cycles; out_valid follows in the next cycle.
  - OUT && out_ready && !in_valid -> IDLE.
  - OUT && out_ready && in_valid -> accept the new request (back-to-back). Next state is OUT or BUSY per the new op. No bubble for single-cycle ops.
  - OUT && !out_ready -> stay in OUT. Outputs are stable and in_ready=0.
- illegal is registered with alu_ctrl and valid only while out_valid=1. It is 0 in IDLE/BUSY except as held from the op in flight.
- Reset values (asynchronous, immediate on rst_n low): state IDLE, cnt 0, alu_ctrl 0, illegal 0, busy 0, out_valid 0. in_ready is 0 while rst_n=0 and 1 from the first cycle after release.
- Reset asserted mid-BUSY or mid-OUT aborts the operation. No output is produced for it.
- Counter never wraps: loaded only on accept, stops at 0.

Test Plan:
- Reset: assert rst_n=0 mid-clock-cycle -> all outputs 0 immediately. After release, in_ready=1, out_valid=0.
- Single-cycle decode: alu_op=10, funct=101010 (SLT), accepted at edge 1, out_ready=1 -> alu_ctrl=0111, out_valid=1 after edge 1 and low after edge 2. Repeat for all ten functs plus alu_op 00/01/11 (funct=111111 ignored).
- Back-to-back: SUB (alu_op=01), then AND (10/100100), then NOR (10/100111) on consecutive edges with out_ready=1 -> alu_ctrl 0110, 0000, 1100 on consecutive cycles, out_valid continuously 1, in_ready continuously 1.
- Multi-cycle: MULT (10/011000) with MUL_LAT=4 -> busy=1 for exactly 4 cycles, in_ready=0, alu_ctrl=1010; then out_valid=1. DIV with DIV_LAT=16 -> busy for 16 cycles.
- Backpressure: ADD accepted with out_ready=0 for 3 cycles -> out_valid=1, alu_ctrl=0010 stable, in_ready=0; completes on the cycle out_ready=1. Illegal funct 111111 -> alu_ctrl=0010, illegal=1.
- Reset mid-op: rst_n=0 during BUSY of DIV at cnt=7 -> busy=0 immediately; after release no out_valid pulse, and the next accepted op decodes normally.
